// File: rtl/sparc_pkg.sv
// SPARC V8 opcode constants, legal-op3 tables and the decoded-entry record
// shared by the decode stage and its field extractor.
package sparc_pkg;

    localparam logic [1:0] OP_BRANCH = 2'b00;
    localparam logic [1:0] OP_CALL   = 2'b01;
    localparam logic [1:0] OP_ALU    = 2'b10;
    localparam logic [1:0] OP_MEM    = 2'b11;

    localparam logic [2:0] OP2_BICC  = 3'b010;
    localparam logic [2:0] OP2_SETHI = 3'b100;

    localparam logic [5:0] OP3_ADD   = 6'b000000;
    localparam logic [5:0] OP3_SUB   = 6'b000100;

    // Bit n set means op3 == n is a defined encoding for that op class.
    localparam logic [63:0] LEGAL_OP3_ALU = 64'h3FFF_0FFF_DDFF_DDFF;
    localparam logic [63:0] LEGAL_OP3_MEM = 64'h00FB_00FB_A6FF_A6FF;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } dec_state_t;

    typedef struct packed {
        logic [1:0]  op;
        logic [2:0]  op2;
        logic [5:0]  op3;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        i;
        logic        a;
        logic [3:0]  cond;
        logic [12:0] simm13;
        logic [21:0] imm22;
        logic [29:0] disp30;
        logic [31:0] pc;
        logic        nop;
        logic        illegal;
    } dec_entry_t;

    function automatic logic op3Legal(input logic [1:0] op, input logic [5:0] op3);
        if (op == OP_ALU) begin
            return LEGAL_OP3_ALU[op3];
        end
        return LEGAL_OP3_MEM[op3];
    endfunction

endpackage

// File: rtl/decode_fields.sv
// Combinational SPARC V8 field extraction with nop/illegal classification.
// Illegal-encoding detection exists only when DEC_ILLEGAL_DETECT_EN is defined.
module decode_fields
    import sparc_pkg::*;
(
    input  logic [31:0] i_inst,
    input  logic [31:0] i_pc,
    output dec_entry_t  o_entry
);

    always_comb begin
        o_entry         = '0;
        o_entry.op      = i_inst[31:30];
        o_entry.rd      = i_inst[29:25];
        o_entry.a       = i_inst[29];
        o_entry.cond    = i_inst[28:25];
        o_entry.op2     = i_inst[24:22];
        o_entry.imm22   = i_inst[21:0];
        o_entry.disp30  = i_inst[29:0];
        o_entry.op3     = i_inst[24:19];
        o_entry.rs1     = i_inst[18:14];
        o_entry.i       = i_inst[13];
        o_entry.simm13  = i_inst[12:0];
        o_entry.rs2     = i_inst[4:0];
        o_entry.pc      = i_pc;
        o_entry.nop     = (i_inst[31:30] == OP_BRANCH) && (i_inst[24:22] == OP2_SETHI)
                          && (i_inst[29:25] == 5'd0);
`ifdef DEC_ILLEGAL_DETECT_EN
        // CALL has no sub-opcode, so every op=01 word is legal.
        case (i_inst[31:30])
            OP_BRANCH: o_entry.illegal = !((i_inst[24:22] == OP2_BICC) ||
                                           (i_inst[24:22] == OP2_SETHI));
            OP_CALL:   o_entry.illegal = 1'b0;
            default:   o_entry.illegal = !op3Legal(i_inst[31:30], i_inst[24:19]);
        endcase
`else
        o_entry.illegal = 1'b0;
`endif
    end

endmodule

// File: rtl/decode_stage.sv
// Two-entry (head + skid) SPARC V8 decode buffer with valid/ready handshakes.
// Optional illegal-encoding flag enabled by DEC_ILLEGAL_DETECT_EN.
module decode_stage
    import sparc_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] DEC_inst_in,
    input  logic [31:0] DEC_PC_in,
    input  logic        DEC_valid_in,
    output logic        DEC_ready_out,
    input  logic        DEC_flush_in,
    output logic        DEC_valid_out,
    input  logic        DEC_ready_in,
    output logic [1:0]  DEC_op_out,
    output logic [2:0]  DEC_op2_out,
    output logic [5:0]  DEC_op3_out,
    output logic [4:0]  DEC_rd_out,
    output logic [4:0]  DEC_rs1_out,
    output logic [4:0]  DEC_rs2_out,
    output logic        DEC_i_out,
    output logic        DEC_a_out,
    output logic [3:0]  DEC_cond_out,
    output logic [12:0] DEC_simm13_out,
    output logic [21:0] DEC_imm22_out,
    output logic [29:0] DEC_disp30_out,
    output logic [31:0] DEC_PC_out,
    output logic        DEC_nop_out,
    output logic        DEC_illegal_out
);

    dec_state_t r_state;
    dec_state_t w_nextState;
    logic       r_ready;
    dec_entry_t r_head;
    dec_entry_t r_skid;
    dec_entry_t w_decoded;
    logic       w_load;
    logic       w_retire;

    decode_fields u_decode_fields (
        .i_inst  (DEC_inst_in),
        .i_pc    (DEC_PC_in),
        .o_entry (w_decoded)
    );

    assign w_load   = DEC_valid_in && r_ready;
    assign w_retire = (r_state != EMPTY) && DEC_ready_in;

    always_comb begin
        w_nextState = r_state;
        if (DEC_flush_in) begin
            w_nextState = EMPTY;
        end else begin
            case (r_state)
                EMPTY: if (w_load) w_nextState = ONE;
                ONE: begin
                    if (w_load && !w_retire) begin
                        w_nextState = TWO;
                    end else if (!w_load && w_retire) begin
                        w_nextState = EMPTY;
                    end
                end
                TWO:     if (w_retire) w_nextState = ONE;
                default: w_nextState = EMPTY;
            endcase
        end
    end

    // Ready is registered from the next state so it never combinationally depends on DEC_ready_in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= EMPTY;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_nextState;
            r_ready <= (w_nextState != TWO);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head <= '0;
            r_skid <= '0;
        end else if (!DEC_flush_in) begin
            case (r_state)
                EMPTY: if (w_load) r_head <= w_decoded;
                ONE: begin
                    if (w_load && w_retire) begin
                        r_head <= w_decoded;
                    end else if (w_load) begin
                        r_skid <= w_decoded;
                    end
                end
                TWO:     if (w_retire) r_head <= r_skid;
                default: ;
            endcase
        end
    end

    assign DEC_ready_out   = r_ready;
    assign DEC_valid_out   = (r_state != EMPTY);
    assign DEC_op_out      = r_head.op;
    assign DEC_op2_out     = r_head.op2;
    assign DEC_op3_out     = r_head.op3;
    assign DEC_rd_out      = r_head.rd;
    assign DEC_rs1_out     = r_head.rs1;
    assign DEC_rs2_out     = r_head.rs2;
    assign DEC_i_out       = r_head.i;
    assign DEC_a_out       = r_head.a;
    assign DEC_cond_out    = r_head.cond;
    assign DEC_simm13_out  = r_head.simm13;
    assign DEC_imm22_out   = r_head.imm22;
    assign DEC_disp30_out  = r_head.disp30;
    assign DEC_PC_out      = r_head.pc;
    assign DEC_nop_out     = r_head.nop;
    assign DEC_illegal_out = r_head.illegal;

endmodule
